alu_sched: RTL and testbench

//  Two-requester scheduler for the shared 4-bit ALU (sel/a/b -> 8-bit y).
//  - Accepts operation requests over valid/ready handshakes.
//  - Arbitrates round-robin and drives registered operands into the external ALU instance.
//  - Waits the ALU settle time, captures y and returns it on one response channel tagged with the requester id.
//  - Sits between the control agents and the single alu instance; one operation in flight at a time.

---
 rtl/alu_sched.sv | 160 ++++++++++++++++
 tb/tb_alu_sched.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler for two requesters sharing one combinational ALU.
// It accepts one request at a time, drives registered operands into the ALU,
// waits ALU_LAT cycles, captures the result, and returns it tagged with the
// requester id.
module alu_sched #(
  parameter int A_W     = 4,
  parameter int SEL_W   = 3,
  parameter int ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [SEL_W-1:0]   req_sel0,
  input  logic [A_W-1:0]     req_a0,
  input  logic [A_W-1:0]     req_b0,
  input  logic [SEL_W-1:0]   req_sel1,
  input  logic [A_W-1:0]     req_a1,
  input  logic [A_W-1:0]     req_b1,
  output logic [SEL_W-1:0]   alu_sel,
  output logic [A_W-1:0]     alu_a,
  output logic [A_W-1:0]     alu_b,
  input  logic [2*A_W-1:0]   alu_y,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*A_W-1:0]   rsp_y,
  output logic               rsp_id,
  output logic               busy
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic               r_lastGrant;
  logic [CNT_W-1:0]   r_cnt;
  logic [SEL_W-1:0]   r_aluSel;
  logic [A_W-1:0]     r_aluA;
  logic [A_W-1:0]     r_aluB;
  logic [2*A_W-1:0]   r_rspY;
  logic               r_rspId;
  logic               r_rspValid;

  logic               w_anyValid;
  logic               w_grant;
  logic               w_accept;
  logic               w_capture;
  logic               w_rspDone;

  // Under contention the requester that did not win last time gets the slot.
  assign w_anyValid = |req_valid;
  assign w_grant    = (req_valid == 2'b11) ? ~r_lastGrant : req_valid[1];

  assign alu_sel   = r_aluSel;
  assign alu_a     = r_aluA;
  assign alu_b     = r_aluB;
  assign rsp_valid = r_rspValid;
  assign rsp_y     = r_rspY;
  assign rsp_id    = r_rspId;

  // State register; reset drops any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and handshake decode; ready is only offered in IDLE and out of reset.
  always_comb begin
    w_stateNext = r_state;
    req_ready   = 2'b00;
    busy        = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_rspDone   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_anyValid && rst_n) begin
          req_ready   = w_grant ? 2'b10 : 2'b01;
          w_accept    = 1'b1;
          w_stateNext = EXEC;
        end
      end
      EXEC: begin
        busy = 1'b1;
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_stateNext = RESP;
        end
      end
      RESP: begin
        busy = 1'b1;
        if (r_rspValid && rsp_ready) begin
          w_rspDone   = 1'b1;
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Operand latch on accept; the ALU inputs hold their values until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aluSel    <= '0;
      r_aluA      <= '0;
      r_aluB      <= '0;
      r_rspId     <= 1'b0;
      r_lastGrant <= 1'b1;
    end else if (w_accept) begin
      r_rspId     <= w_grant;
      r_lastGrant <= w_grant;
      if (w_grant) begin
        r_aluSel <= req_sel1;
        r_aluA   <= req_a1;
        r_aluB   <= req_b1;
      end else begin
        r_aluSel <= req_sel0;
        r_aluA   <= req_a0;
        r_aluB   <= req_b0;
      end
    end
  end

  // Settle counter: loaded on accept, counts down while the ALU output settles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= CNT_INIT;
    end else if ((r_state == EXEC) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Response register: captures the ALU result and holds it until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rspY     <= '0;
      r_rspValid <= 1'b0;
    end else if (w_capture) begin
      r_rspY     <= alu_y;
      r_rspValid <= 1'b1;
    end else if (w_rspDone) begin
      r_rspValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed and randomized checks of alu_sched against a
// transaction-level model of the scheduler, with a multiplier standing in for the ALU.
module tb_alu_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rst_n3;
  logic [1:0] req_valid;
  logic [2:0] req_sel0, req_sel1;
  logic [3:0] req_a0, req_b0, req_a1, req_b1;
  logic       rsp_ready;

  logic [1:0] req_ready, req_ready3;
  logic [2:0] alu_sel, alu_sel3;
  logic [3:0] alu_a, alu_b, alu_a3, alu_b3;
  logic [7:0] alu_y, alu_y3;
  logic       rsp_valid, rsp_valid3;
  logic [7:0] rsp_y, rsp_y3;
  logic       rsp_id, rsp_id3;
  logic       busy, busy3;

  int testsRun = 0;
  int testsFailed = 0;

  // Model of the scheduler, tracked per transaction rather than per state.
  bit         mBusy, mLast, mRspValid, mRspId;
  int         mWait;
  logic [2:0] mSel;
  logic [3:0] mA, mB;
  logic [7:0] mY, mRspY;
  logic [1:0] mAccepted;
  int         cycleNum = 0;
  int         dutAcceptId[$];
  int         dutAcceptCyc[$];

  always #5 clk = ~clk;

  // Stand-in ALU: product of the registered operands.
  assign alu_y  = {4'b0, alu_a} * {4'b0, alu_b};
  assign alu_y3 = {4'b0, alu_a3} * {4'b0, alu_b3};

  alu_sched #(.A_W(4), .SEL_W(3), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel0(req_sel0), .req_a0(req_a0), .req_b0(req_b0),
    .req_sel1(req_sel1), .req_a1(req_a1), .req_b1(req_b1),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_id(rsp_id), .busy(busy)
  );

  alu_sched #(.A_W(4), .SEL_W(3), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n3), .req_valid(req_valid), .req_ready(req_ready3),
    .req_sel0(req_sel0), .req_a0(req_a0), .req_b0(req_b0),
    .req_sel1(req_sel1), .req_a1(req_a1), .req_b1(req_b1),
    .alu_sel(alu_sel3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_y(alu_y3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_y(rsp_y3),
    .rsp_id(rsp_id3), .busy(busy3)
  );

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v,
                               input logic [2:0] s0, input logic [3:0] a0, input logic [3:0] b0,
                               input logic [2:0] s1, input logic [3:0] a1, input logic [3:0] b1,
                               input logic rr);
    req_valid = v;
    req_sel0 = s0; req_a0 = a0; req_b0 = b0;
    req_sel1 = s1; req_a1 = a1; req_b1 = b1;
    rsp_ready = rr;
  endtask

  // Checks the main DUT against the model at the falling edge, then advances the
  // model over the coming rising edge and returns just after it.
  task automatic checkOutput();
    logic [1:0] expReady;
    bit         g;
    @(negedge clk);
    cycleNum++;
    if (!rst_n) begin
      mBusy = 0; mLast = 1; mRspValid = 0; mRspId = 0; mWait = 0;
      mSel = '0; mA = '0; mB = '0; mY = '0; mRspY = '0;
    end
    expReady = 2'b00;
    g = 1'b0;
    if (rst_n && !mBusy && (req_valid != 2'b00)) begin
      if (req_valid[0] && req_valid[1]) g = (mLast == 1'b0);
      else                              g = req_valid[1];
      expReady = g ? 2'b10 : 2'b01;
    end
    compare("req_ready", 32'(req_ready), 32'(expReady));
    compare("busy",      32'(busy),      32'(mBusy));
    compare("rsp_valid", 32'(rsp_valid), 32'(mRspValid));
    compare("rsp_y",     32'(rsp_y),     32'(mRspY));
    compare("rsp_id",    32'(rsp_id),    32'(mRspId));
    compare("alu_sel",   32'(alu_sel),   32'(mSel));
    compare("alu_a",     32'(alu_a),     32'(mA));
    compare("alu_b",     32'(alu_b),     32'(mB));
    if (rst_n && ((req_ready & req_valid) != 2'b00)) begin
      dutAcceptId.push_back(int'(req_ready[1]));
      dutAcceptCyc.push_back(cycleNum);
    end
    mAccepted = expReady;
    if (rst_n) begin
      if (expReady != 2'b00) begin
        mBusy = 1; mLast = g; mRspId = g; mWait = 1;
        if (g) begin mSel = req_sel1; mA = req_a1; mB = req_b1; end
        else   begin mSel = req_sel0; mA = req_a0; mB = req_b0; end
        mY = {4'b0, mA} * {4'b0, mB};
      end else if (mBusy && !mRspValid) begin
        mWait--;
        if (mWait == 0) begin mRspValid = 1; mRspY = mY; end
      end else if (mRspValid && rsp_ready) begin
        mRspValid = 0; mBusy = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Hard stop in case anything stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  waited;
    bit  pend0, pend1;
    rst_n = 1'b0; rst_n3 = 1'b0;
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 1'b0);

    // Reset held with random inputs
    repeat (4) begin
      applyStimulus(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      #1;
      compare("rst_ready", 32'(req_ready), 32'd0);
      compare("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput();
    end
    rst_n = 1'b1;
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 1'b0);
    checkOutput();

    // Single op from requester 0
    applyStimulus(2'b01, 3'd3, 4'd13, 4'd11, 0, 0, 0, 1'b0);
    #1;
    compare("t2_ready", 32'(req_ready), 32'h1);
    checkOutput();
    compare("t2_alu_sel", 32'(alu_sel), 32'd3);
    compare("t2_alu_a", 32'(alu_a), 32'd13);
    compare("t2_alu_b", 32'(alu_b), 32'd11);
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 1'b0);
    checkOutput();
    compare("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    compare("t2_rsp_y", 32'(rsp_y), 32'h8F);
    compare("t2_rsp_id", 32'(rsp_id), 32'd0);
    rsp_ready = 1'b1;
    checkOutput();

    // Contention from reset: grants alternate, three cycles apart
    rst_n = 1'b0;
    checkOutput();
    rst_n = 1'b1;
    dutAcceptId.delete();
    dutAcceptCyc.delete();
    applyStimulus(2'b11, 3'd1, 4'd2, 4'd3, 3'd2, 4'd5, 4'd7, 1'b1);
    repeat (12) checkOutput();
    compare("t3_accepts", 32'(dutAcceptId.size()), 32'd4);
    if (dutAcceptId.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        compare("t3_grant_id", 32'(dutAcceptId[k]), 32'(k % 2));
      end
      for (int k = 0; k < 3; k++) begin
        compare("t3_gap", 32'(dutAcceptCyc[k+1] - dutAcceptCyc[k]), 32'd3);
      end
    end
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 1'b0);
    checkOutput();

    // Backpressure on the response channel
    applyStimulus(2'b10, 0, 0, 0, 3'd6, 4'd9, 4'd6, 1'b0);
    checkOutput();
    applyStimulus(2'b11, 3'd2, 4'd1, 4'd1, 3'd6, 4'd9, 4'd6, 1'b0);
    checkOutput();
    repeat (5) begin
      checkOutput();
      compare("t4_rsp_y", 32'(rsp_y), 32'h36);
      compare("t4_rsp_id", 32'(rsp_id), 32'd1);
      compare("t4_ready", 32'(req_ready), 32'd0);
      compare("t4_busy", 32'(busy), 32'd1);
    end
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    checkOutput();
    compare("t4_busy_after", 32'(busy), 32'd0);
    compare("t4_valid_after", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;
    checkOutput();

    // Reset while an op is executing
    applyStimulus(2'b01, 3'd5, 4'd7, 4'd3, 0, 0, 0, 1'b1);
    checkOutput();
    rst_n = 1'b0;
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    repeat (3) begin
      checkOutput();
      compare("t5_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rst_n = 1'b1;
    applyStimulus(2'b11, 3'd2, 4'd4, 4'd4, 3'd6, 4'd3, 4'd3, 1'b1);
    checkOutput();
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 1'b1);
    checkOutput();
    compare("t5_rsp_valid", 32'(rsp_valid), 32'd1);
    compare("t5_rsp_id", 32'(rsp_id), 32'd0);
    compare("t5_rsp_y", 32'(rsp_y), 32'h10);
    checkOutput();

    // Randomized traffic with protocol-abiding requesters
    pend0 = 0; pend1 = 0;
    for (int c = 0; c < 300; c++) begin
      if (!pend0 && ($urandom_range(0, 2) == 0)) begin
        pend0 = 1;
        req_sel0 = 3'($urandom_range(0, 7));
        req_a0 = 4'($urandom_range(0, 15));
        req_b0 = 4'($urandom_range(0, 15));
      end else if (pend0 && ($urandom_range(0, 15) == 0)) begin
        pend0 = 0;
      end
      if (!pend1 && ($urandom_range(0, 2) == 0)) begin
        pend1 = 1;
        req_sel1 = 3'($urandom_range(0, 7));
        req_a1 = 4'($urandom_range(0, 15));
        req_b1 = 4'($urandom_range(0, 15));
      end else if (pend1 && ($urandom_range(0, 15) == 0)) begin
        pend1 = 0;
      end
      req_valid = {pend1, pend0};
      rsp_ready = 1'($urandom_range(0, 1));
      checkOutput();
      if (mAccepted[0]) pend0 = 0;
      if (mAccepted[1]) pend1 = 0;
    end

    // Longer ALU settle time on the second instance
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 1'b0);
    rst_n = 1'b0; rst_n3 = 1'b0;
    checkOutput();
    rst_n = 1'b1; rst_n3 = 1'b1;
    applyStimulus(2'b10, 0, 0, 0, 3'd4, 4'd15, 4'd15, 1'b0);
    #1;
    compare("t6_ready", 32'(req_ready3), 32'h2);
    checkOutput();
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 1'b0);
    compare("t6_alu_a", 32'(alu_a3), 32'd15);
    compare("t6_busy", 32'(busy3), 32'd1);
    waited = 0;
    while (!rsp_valid3 && (waited < 10)) begin
      checkOutput();
      waited++;
    end
    compare("t6_latency", 32'(waited), 32'd3);
    compare("t6_rsp_y", 32'(rsp_y3), 32'hE1);
    compare("t6_rsp_id", 32'(rsp_id3), 32'd1);
    rsp_ready = 1'b1;
    checkOutput();
    compare("t6_valid_after", 32'(rsp_valid3), 32'd0);
    compare("t6_busy_after", 32'(busy3), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
